// File: rtl/input_vc_buffer.sv
// Router input virtual-channel buffer: FIFO of single-flit packets filled over a
// req/gnt handshake, drained towards the output-port arbiters using XY routing.
module input_vc_buffer #(
    parameter int         DEPTH = 4,
    parameter logic [3:0] CUR_X = 4'd0,
    parameter logic [3:0] CUR_Y = 4'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_up,
    input  logic [31:0]              packet_in,
    output logic                     gnt_up,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [4:0]               req_out,
    input  logic [4:0]               gnt_out,
    output logic [31:0]              packet_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_ACK = 1'b1} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ROUTE = 2'd1, R_WAIT_GNT = 2'd2} r_state_t;

    // XY routing, X resolved first; one-hot {West, South, East, North, Local}
    function automatic logic [4:0] xy_route(input logic [3:0] dx, input logic [3:0] dy);
        logic [4:0] dir;
        if (dx > CUR_X) begin
            dir = 5'b00100;
        end else if (dx < CUR_X) begin
            dir = 5'b10000;
        end else if (dy > CUR_Y) begin
            dir = 5'b01000;
        end else if (dy < CUR_Y) begin
            dir = 5'b00010;
        end else begin
            dir = 5'b00001;
        end
        return dir;
    endfunction

    logic [31:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          full_r;
    logic          gnt_up_r;
    logic [4:0]    req_out_r;
    logic [31:0]   packet_out_r;
    w_state_t      w_state_r;
    w_state_t      w_state_next_s;
    r_state_t      r_state_r;
    r_state_t      r_state_next_s;
    logic          wr_en_s;
    logic          pop_s;
    logic          route_load_s;
    logic [31:0]   head_s;

    assign head_s = mem_r[rd_ptr_r];

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_r <= W_IDLE;
        end else begin
            w_state_r <= w_state_next_s;
        end
    end

    // Write FSM next state: W_ACK waits for upstream to drop req so each request writes once
    always_comb begin
        w_state_next_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (req_up && !full_r) begin
                    w_state_next_s = W_ACK;
                end else begin
                    w_state_next_s = W_IDLE;
                end
            end
            W_ACK: begin
                if (!req_up) begin
                    w_state_next_s = W_IDLE;
                end else begin
                    w_state_next_s = W_ACK;
                end
            end
            default: w_state_next_s = W_IDLE;
        endcase
    end

    // Write FSM outputs; uses the registered full, so a same-edge pop cannot unblock a write
    always_comb begin
        wr_en_s = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (req_up && !full_r) begin
                    wr_en_s = 1'b1;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            W_ACK:   wr_en_s = 1'b0;
            default: wr_en_s = 1'b0;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_r <= R_IDLE;
        end else begin
            r_state_r <= r_state_next_s;
        end
    end

    // Read FSM next state
    always_comb begin
        r_state_next_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (count_r != CNT_ZERO) begin
                    r_state_next_s = R_ROUTE;
                end else begin
                    r_state_next_s = R_IDLE;
                end
            end
            R_ROUTE: r_state_next_s = R_WAIT_GNT;
            R_WAIT_GNT: begin
                if (pop_s) begin
                    if (count_next_s != CNT_ZERO) begin
                        r_state_next_s = R_ROUTE;
                    end else begin
                        r_state_next_s = R_IDLE;
                    end
                end else begin
                    r_state_next_s = R_WAIT_GNT;
                end
            end
            default: r_state_next_s = R_IDLE;
        endcase
    end

    // Read FSM outputs; grants on unrequested ports are masked off
    always_comb begin
        pop_s        = 1'b0;
        route_load_s = 1'b0;
        case (r_state_r)
            R_IDLE:     route_load_s = 1'b0;
            R_ROUTE:    route_load_s = 1'b1;
            R_WAIT_GNT: pop_s = ((gnt_out & req_out_r) != 5'b00000);
            default: begin
                pop_s        = 1'b0;
                route_load_s = 1'b0;
            end
        endcase
    end

    // Occupancy after this edge
    always_comb begin
        count_next_s = count_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Storage is deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= packet_in;
        end
    end

    // Pointers, occupancy and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            count_r      <= CNT_ZERO;
            full_r       <= 1'b0;
            gnt_up_r     <= 1'b0;
            req_out_r    <= 5'b00000;
            packet_out_r <= 32'h0000_0000;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r  <= count_next_s;
            full_r   <= (count_next_s == DEPTH_C);
            gnt_up_r <= wr_en_s;
            if (route_load_s) begin
                req_out_r    <= xy_route(head_s[31:28], head_s[27:24]);
                packet_out_r <= head_s;
            end else if (pop_s) begin
                req_out_r <= 5'b00000;
            end
        end
    end

    assign gnt_up     = gnt_up_r;
    assign full       = full_r;
    assign count      = count_r;
    assign req_out    = req_out_r;
    assign packet_out = packet_out_r;

endmodule

// File: tb/tb_input_vc_buffer.sv
// Self-checking bench for input_vc_buffer (DEPTH 4, router at (1,1)): directed
// scenarios plus a randomized run against a queue-based reference model.
module tb_input_vc_buffer;

    localparam logic [3:0] CX = 4'd1;
    localparam logic [3:0] CY = 4'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_up = 1'b0;
    logic [31:0] packet_in = 32'h0;
    logic        gnt_up;
    logic        full;
    logic [2:0]  count;
    logic [4:0]  req_out;
    logic [4:0]  gnt_out = 5'b0;
    logic [31:0] packet_out;

    int checks = 0;
    int errors = 0;

    input_vc_buffer #(.DEPTH(4), .CUR_X(CX), .CUR_Y(CY)) dut (
        .clk(clk), .rst(rst), .req_up(req_up), .packet_in(packet_in),
        .gnt_up(gnt_up), .full(full), .count(count), .req_out(req_out),
        .gnt_out(gnt_out), .packet_out(packet_out)
    );

    always #5 clk = ~clk;

    // Expected direction from the XY rule: East/West first, then South/North, else Local
    function automatic logic [4:0] exp_route(input logic [31:0] p);
        if (p[31:28] > CX) return 5'b00100;
        if (p[31:28] < CX) return 5'b10000;
        if (p[27:24] > CY) return 5'b01000;
        if (p[27:24] < CY) return 5'b00010;
        return 5'b00001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; req_up = 1'b0; gnt_out = 5'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    // Upstream side of one handshake: raise req, wait for gnt, drop req
    task automatic send_pkt(input logic [31:0] p);
        req_up = 1'b1; packet_in = p;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (gnt_up === 1'b1) break;
        end
        checks++;
        if (gnt_up !== 1'b1) begin
            errors++; $display("FAIL send_timeout: gnt_up=%b required 1 for %h", gnt_up, p);
        end
        req_up = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; req_up = 1'b1; packet_in = 32'h1100_0001; gnt_out = 5'b0;
        tick(); tick();
        checks++; if (gnt_up !== 1'b0) begin errors++; $display("FAIL reset_gnt_up: got %b required 0", gnt_up); end
        checks++; if (req_out !== 5'b0) begin errors++; $display("FAIL reset_req_out: got %b required 00000", req_out); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b required 0", full); end
        checks++; if (packet_out !== 32'h0) begin errors++; $display("FAIL reset_packet_out: got %h required 0", packet_out); end
        rst = 1'b1;
        tick();
        checks++; if (gnt_up !== 1'b1) begin errors++; $display("FAIL reset_first_ack: got %b required 1", gnt_up); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL reset_first_count: got %0d required 1", count); end
        req_up = 1'b0;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        req_up = 1'b1; packet_in = 32'h3100_00AA;
        tick();
        checks++; if (gnt_up !== 1'b1) begin errors++; $display("FAIL single_ack: got %b required 1", gnt_up); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d required 1", count); end
        req_up = 1'b0;
        tick();
        checks++; if (gnt_up !== 1'b0) begin errors++; $display("FAIL single_ack_pulse: got %b required 0", gnt_up); end
        checks++; if (req_out !== 5'b0) begin errors++; $display("FAIL single_req_early: got %b required 00000", req_out); end
        tick();
        checks++; if (req_out !== 5'b00100) begin errors++; $display("FAIL single_req_out: got %b required 00100", req_out); end
        checks++; if (packet_out !== 32'h3100_00AA) begin errors++; $display("FAIL single_packet_out: got %h required 310000aa", packet_out); end
        gnt_out = 5'b00100;
        tick();
        gnt_out = 5'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_pop_count: got %0d required 0", count); end
        checks++; if (req_out !== 5'b0) begin errors++; $display("FAIL single_pop_req: got %b required 00000", req_out); end
    endtask

    task automatic test_routing();
        logic [31:0] pk [7] = '{32'h0100_0001, 32'h1000_0002, 32'h1200_0003, 32'h1100_0004,
                                32'h3300_0005, 32'h0000_0006, 32'h1500_0007};
        logic [4:0]  ex [7] = '{5'b10000, 5'b00010, 5'b01000, 5'b00001,
                                5'b00100, 5'b10000, 5'b01000};
        for (int i = 0; i < 7; i++) begin
            apply_reset();
            send_pkt(pk[i]);
            for (int c = 0; c < 10 && req_out === 5'b0; c++) tick();
            checks++;
            if (req_out !== ex[i]) begin
                errors++; $display("FAIL route_%0d: req_out %b required %b", i, req_out, ex[i]);
            end
            gnt_out = 5'b11111;
            tick();
            gnt_out = 5'b0;
            checks++; if (count !== 3'd0) begin errors++; $display("FAIL route_pop_%0d: count %0d required 0", i, count); end
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 4; i++) send_pkt(32'h2200_0100 + 32'(i));
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d required 4", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b required 1", full); end
        req_up = 1'b1; packet_in = 32'h2200_0104;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (gnt_up !== 1'b0 || count !== 3'd4) begin
                errors++; $display("FAIL full_blocked: gnt_up %b count %0d required 0 and 4", gnt_up, count);
            end
        end
        checks++; if (packet_out !== 32'h2200_0100) begin errors++; $display("FAIL full_head: got %h required 22000100", packet_out); end
        gnt_out = req_out;
        tick();
        gnt_out = 5'b0;
        checks++; if (gnt_up !== 1'b0 || count !== 3'd3 || full !== 1'b0) begin
            errors++; $display("FAIL full_pop_edge: gnt_up %b count %0d full %b required 0 3 0", gnt_up, count, full);
        end
        tick();
        checks++; if (gnt_up !== 1'b1 || count !== 3'd4 || full !== 1'b1) begin
            errors++; $display("FAIL full_refill: gnt_up %b count %0d full %b required 1 4 1", gnt_up, count, full);
        end
        req_up = 1'b0;
        tick();
    endtask

    task automatic test_order_wrap();
        int sent = 0;
        int got = 0;
        logic pop_pend;
        logic [31:0] seen;
        apply_reset();
        gnt_out = 5'b00001;
        req_up = 1'b1; packet_in = 32'h1100_0000;
        for (int c = 0; c < 200 && got < 10; c++) begin
            pop_pend = ((req_out & gnt_out) != 5'b0);
            seen = packet_out;
            tick();
            if (pop_pend) begin
                checks++;
                if (seen !== 32'h1100_0000 + 32'(got)) begin
                    errors++; $display("FAIL order_%0d: got %h required %h", got, seen, 32'h1100_0000 + 32'(got));
                end
                got++;
            end
            if (gnt_up === 1'b1) begin
                sent++; req_up = 1'b0;
            end else if (!req_up && sent < 10) begin
                req_up = 1'b1; packet_in = 32'h1100_0000 + 32'(sent);
            end
        end
        for (int c = 0; c < 5; c++) tick();
        checks++; if (got != 10 || sent != 10) begin errors++; $display("FAIL order_total: popped %0d sent %0d required 10 10", got, sent); end
        checks++; if (count !== 3'd0 || req_out !== 5'b0) begin
            errors++; $display("FAIL order_drained: count %0d req_out %b required 0 00000", count, req_out);
        end
        gnt_out = 5'b0;
    endtask

    task automatic test_spurious();
        apply_reset();
        req_up = 1'b1; packet_in = 32'h3100_0055;
        tick();
        checks++; if (gnt_up !== 1'b1) begin errors++; $display("FAIL hold_ack: got %b required 1", gnt_up); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (gnt_up !== 1'b0 || count !== 3'd1) begin
                errors++; $display("FAIL hold_single_write: gnt_up %b count %0d required 0 1", gnt_up, count);
            end
        end
        checks++; if (req_out !== 5'b00100) begin errors++; $display("FAIL spur_req: got %b required 00100", req_out); end
        gnt_out = 5'b00010;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (req_out !== 5'b00100 || count !== 3'd1) begin
                errors++; $display("FAIL spur_ignored: req_out %b count %0d required 00100 1", req_out, count);
            end
        end
        req_up = 1'b0; gnt_out = 5'b00100;
        tick();
        gnt_out = 5'b0;
        checks++; if (count !== 3'd0 || req_out !== 5'b0) begin
            errors++; $display("FAIL spur_real_pop: count %0d req_out %b required 0 00000", count, req_out);
        end
    endtask

    // Random traffic vs. a plain FIFO queue model
    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] cur;
        logic pop_pend = 1'b0;
        logic was_full = 1'b0;
        int pops = 0;
        int r;
        apply_reset();
        cur = 32'h0;
        for (int c = 0; c < 1500; c++) begin
            if (pop_pend) begin
                void'(q.pop_front()); pops++;
            end
            if (gnt_up === 1'b1) begin
                checks++; if (was_full) begin errors++; $display("FAIL rand_ack_when_full: gnt_up %b required 0", gnt_up); end
                q.push_back(cur); req_up = 1'b0;
            end
            checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rand_count: got %0d required %0d", count, q.size()); end
            checks++; if (full !== (q.size() == 4)) begin errors++; $display("FAIL rand_full: got %b required %b", full, q.size() == 4); end
            if (req_out !== 5'b0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_req_empty: req_out %b required 00000", req_out);
                end else if (packet_out !== q[0] || req_out !== exp_route(q[0])) begin
                    errors++; $display("FAIL rand_head: got %h/%b required %h/%b", packet_out, req_out, q[0], exp_route(q[0]));
                end
            end
            if (!req_up && gnt_up !== 1'b1 && $urandom_range(0, 2) != 0) begin
                cur = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 24'($urandom)};
                req_up = 1'b1; packet_in = cur;
            end
            r = $urandom_range(0, 3);
            if (r < 2) gnt_out = req_out;
            else if (r == 2) gnt_out = 5'($urandom);
            else gnt_out = 5'b0;
            pop_pend = ((req_out & gnt_out) != 5'b0);
            was_full = (q.size() == 4);
            tick();
        end
        checks++; if (pops < 50) begin errors++; $display("FAIL rand_progress: pops %0d required at least 50", pops); end
        gnt_out = 5'b0; req_up = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_routing();
        test_full();
        test_order_wrap();
        test_spurious();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
